idexe_hazard_stage: RTL
=======================

Name: idexe_hazard_stage

Overview:
- ID/EXE pipeline register with integrated RAW hazard resolution for the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID, forwards EXE/MEM/WB results into the operands at capture time, and detects load-use hazards.
- On a load-use hazard it stalls IF/ID for one cycle and inserts a bubble, so the EXE stage always receives resolved operands.
- Also keeps a saturating stall counter for performance debug.

Parameters:
- NOP_ALUCTRL, 6'h00, ALUControl value driven for a bubble
- CNT_W, 32, stall counter width

Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- ID_Valid_IN  in  1  ID holds a real instruction
- ID_OperandA_IN / ID_OperandB_IN  in  32  register-file read data
- ID_RegA_IN / ID_RegB_IN  in  5  source register numbers
- ID_UseA_IN / ID_UseB_IN  in  1  source actually read (immediate forms clear UseB)
- ID_ALUControl_IN  in  6  ALU opcode
- ID_ShiftAmount_IN  in  5  shamt
- ID_WriteReg_IN  in  5  destination register
- ID_RegWrite_IN  in  1  writes register file
- ID_MemRead_IN  in  1  instruction is a load
- EXE_ALUResult_IN  in  32  ALU result of the instruction currently held in this block
- MEM_WriteReg_IN  in  5  EXE/MEM destination
- MEM_RegWrite_IN  in  1  EXE/MEM writes register file
- MEM_Data_IN  in  32  EXE/MEM result (load data when a load)
- WB_WriteReg_IN  in  5  MEM/WB destination
- WB_RegWrite_IN  in  1  MEM/WB writes register file
- WB_Data_IN  in  32  writeback data
- Flush_IN  in  1  kill the instruction entering EXE
- Stall_OUT  out  1  hold PC and IF/ID (combinational)
- Valid_OUT  out  1  EXE holds a real instruction
- OperandA_OUT / OperandB_OUT  out  32  resolved operands to EXE
- ALUControl_OUT  out  6  to EXE
- ShiftAmount_OUT  out  5  to EXE
- WriteReg_OUT  out  5  destination
- RegWrite_OUT  out  1  writes register file
- MemRead_OUT  out  1  load
- StallCount_OUT  out  CNT_W  number of stall cycles, saturating

Behaviour:
- Reset (asynchronous, active-low, may arrive mid-operation) clears all registered outputs to 0 and sets ALUControl_OUT=NOP_ALUCTRL. Stall_OUT=0 while RESET=0.
- Match condition for source X (A or B): ID_UseX_IN & (ID_RegX_IN != 0) & (producer dest == ID_RegX_IN) & producer write-enable.
  - EXE producer: Valid_OUT & RegWrite_OUT, dest = WriteReg_OUT.
  - MEM producer: MEM_RegWrite_IN, dest = MEM_WriteReg_IN.
  - WB producer: WB_RegWrite_IN, dest = WB_WriteReg_IN.
- Load-use hazard = ID_Valid_IN & MemRead_OUT & EXE match on A or B.
- Stall_OUT = hazard & ~Flush_IN.
- Operand select per source, priority EXE > MEM > WB > ID_OperandX_IN:
  - EXE match and not MemRead_OUT -> EXE_ALUResult_IN
  - MEM match -> MEM_Data_IN
  - WB match -> WB_Data_IN
- Register 0 never forwards. Unused sources pass ID data unchanged.
- Next state at the rising edge, in priority order:
  1. Flush_IN=1 -> bubble.
  2. Hazard -> bubble (ID instruction retained upstream via Stall_OUT).
  3. Otherwise -> capture the ID fields with forwarded operands; Valid_OUT=ID_Valid_IN. When ID_Valid_IN=0, RegWrite_OUT and MemRead_OUT are forced to 0.
- Bubble: Valid_OUT=0, RegWrite_OUT=0, MemRead_OUT=0, ALUControl_OUT=NOP_ALUCTRL, WriteReg_OUT=0, operands 0.
- Latency: 1 cycle ID->EXE; load-use adds exactly 1 bubble cycle. On the following cycle the load sits in MEM and its data forwards via MEM_Data_IN.
- Two back-to-back loads feeding a use: one stall only.
- StallCount_OUT increments on each edge where Stall_OUT=1 and saturates at all-ones (no wrap).
- A flush coincident with a hazard produces a bubble, no stall, and no count increment.

Decomposition:
- Shared package pipe_pkg: NOP_ALUCTRL, REG_ZERO=5'd0, and an idexe_ctrl_t struct (ALUControl, ShiftAmount, WriteReg, RegWrite, MemRead, Valid).
- Sub-module fwd_select: combinational per-operand priority mux with match logic, instantiated twice (A, B).

Test Plan:
- Reset mid-stream: RESET low while Valid_OUT=1 -> all outputs 0, ALUControl_OUT=6'h00 immediately; StallCount_OUT=0.
- EXE forward: `add $3,$1,$2` in EXE with EXE_ALUResult_IN=32'h0000_0010, ID `sub $4,$3,$5` -> next cycle OperandA_OUT=32'h10, Stall_OUT=0.
- Priority: $7 matched by MEM (32'hAAAA_0000) and WB (32'h5555_0000) simultaneously -> OperandB_OUT=32'hAAAA_0000. The same match with ID_RegB_IN=0 -> ID operand passes.
- Load-use: `lw $8` in EXE, ID `add $9,$8,$8` -> Stall_OUT=1 for one cycle, bubble (Valid_OUT=0, RegWrite_OUT=0). Next cycle MEM_Data_IN=32'hDEAD_BEEF -> both operands DEAD_BEEF, StallCount_OUT=1.
- Flush during hazard: load-use condition with Flush_IN=1 -> Stall_OUT=0, bubble captured, StallCount_OUT unchanged.
- Saturation: CNT_W=4, force 20 consecutive hazard cycles -> StallCount_OUT holds 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble opcode, the hardwired-zero register and
// the control bundle carried through the ID/EXE register.
package pipe_pkg;

  localparam logic [5:0] NOP_ALUCTRL = 6'h00;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  typedef struct packed {
    logic [5:0] ALUControl;
    logic [4:0] ShiftAmount;
    logic [4:0] WriteReg;
    logic       RegWrite;
    logic       MemRead;
    logic       Valid;
  } idexe_ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand RAW resolution: priority EXE > MEM > WB > register file.
// exeMatch is exported so the caller can detect load-use hazards.
module fwd_select
  import pipe_pkg::*;
(
  input  logic        useSrc,
  input  logic [4:0]  srcReg,
  input  logic [31:0] idData,
  input  logic        exeWrite,
  input  logic [4:0]  exeDest,
  input  logic        exeLoad,
  input  logic [31:0] exeData,
  input  logic        memWrite,
  input  logic [4:0]  memDest,
  input  logic [31:0] memData,
  input  logic        wbWrite,
  input  logic [4:0]  wbDest,
  input  logic [31:0] wbData,
  output logic        exeMatch,
  output logic [31:0] fwdData
);

  logic live;
  logic memMatch;
  logic wbMatch;

  assign live     = useSrc && (srcReg != REG_ZERO);
  assign exeMatch = live && exeWrite && (exeDest == srcReg);
  assign memMatch = live && memWrite && (memDest == srcReg);
  assign wbMatch  = live && wbWrite  && (wbDest  == srcReg);

  // A load in EXE has no data yet; the stage stalls, so falling through is harmless.
  always_comb begin
    fwdData = idData;
    if (exeMatch && !exeLoad) fwdData = exeData;
    else if (memMatch)        fwdData = memData;
    else if (wbMatch)         fwdData = wbData;
  end

endmodule

// File: rtl/idexe_hazard_stage.sv
// ID/EXE pipeline register with capture-time forwarding, load-use stall and
// bubble insertion, plus a saturating stall counter.
module idexe_hazard_stage #(
  parameter logic [5:0] NOP_ALUCTRL = pipe_pkg::NOP_ALUCTRL,
  parameter int         CNT_W       = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ID_Valid_IN,
  input  logic [31:0]      ID_OperandA_IN,
  input  logic [31:0]      ID_OperandB_IN,
  input  logic [4:0]       ID_RegA_IN,
  input  logic [4:0]       ID_RegB_IN,
  input  logic             ID_UseA_IN,
  input  logic             ID_UseB_IN,
  input  logic [5:0]       ID_ALUControl_IN,
  input  logic [4:0]       ID_ShiftAmount_IN,
  input  logic [4:0]       ID_WriteReg_IN,
  input  logic             ID_RegWrite_IN,
  input  logic             ID_MemRead_IN,
  input  logic [31:0]      EXE_ALUResult_IN,
  input  logic [4:0]       MEM_WriteReg_IN,
  input  logic             MEM_RegWrite_IN,
  input  logic [31:0]      MEM_Data_IN,
  input  logic [4:0]       WB_WriteReg_IN,
  input  logic             WB_RegWrite_IN,
  input  logic [31:0]      WB_Data_IN,
  input  logic             Flush_IN,
  output logic             Stall_OUT,
  output logic             Valid_OUT,
  output logic [31:0]      OperandA_OUT,
  output logic [31:0]      OperandB_OUT,
  output logic [5:0]       ALUControl_OUT,
  output logic [4:0]       ShiftAmount_OUT,
  output logic [4:0]       WriteReg_OUT,
  output logic             RegWrite_OUT,
  output logic             MemRead_OUT,
  output logic [CNT_W-1:0] StallCount_OUT
);

  localparam pipe_pkg::idexe_ctrl_t BUBBLE = '{NOP_ALUCTRL, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};

  pipe_pkg::idexe_ctrl_t ctrlQ, ctrlD;
  logic [31:0]      operandAQ, operandBQ, operandAD, operandBD;
  logic [31:0]      fwdA, fwdB;
  logic             exeMatchA, exeMatchB;
  logic             exeWrite;
  logic             hazard;
  logic [CNT_W-1:0] stallCount;

  assign exeWrite = ctrlQ.Valid && ctrlQ.RegWrite;

  fwd_select u_fwdA (
    .useSrc(ID_UseA_IN), .srcReg(ID_RegA_IN), .idData(ID_OperandA_IN),
    .exeWrite(exeWrite), .exeDest(ctrlQ.WriteReg), .exeLoad(ctrlQ.MemRead),
    .exeData(EXE_ALUResult_IN),
    .memWrite(MEM_RegWrite_IN), .memDest(MEM_WriteReg_IN), .memData(MEM_Data_IN),
    .wbWrite(WB_RegWrite_IN), .wbDest(WB_WriteReg_IN), .wbData(WB_Data_IN),
    .exeMatch(exeMatchA), .fwdData(fwdA)
  );

  fwd_select u_fwdB (
    .useSrc(ID_UseB_IN), .srcReg(ID_RegB_IN), .idData(ID_OperandB_IN),
    .exeWrite(exeWrite), .exeDest(ctrlQ.WriteReg), .exeLoad(ctrlQ.MemRead),
    .exeData(EXE_ALUResult_IN),
    .memWrite(MEM_RegWrite_IN), .memDest(MEM_WriteReg_IN), .memData(MEM_Data_IN),
    .wbWrite(WB_RegWrite_IN), .wbDest(WB_WriteReg_IN), .wbData(WB_Data_IN),
    .exeMatch(exeMatchB), .fwdData(fwdB)
  );

  assign hazard    = ID_Valid_IN && ctrlQ.MemRead && (exeMatchA || exeMatchB);
  // A flush kills the consumer, so there is nothing left to stall for.
  assign Stall_OUT = RESET && hazard && !Flush_IN;

  always_comb begin
    ctrlD     = BUBBLE;
    operandAD = '0;
    operandBD = '0;
    if (!Flush_IN && !hazard) begin
      ctrlD.ALUControl  = ID_ALUControl_IN;
      ctrlD.ShiftAmount = ID_ShiftAmount_IN;
      ctrlD.WriteReg    = ID_WriteReg_IN;
      ctrlD.RegWrite    = ID_RegWrite_IN && ID_Valid_IN;
      ctrlD.MemRead     = ID_MemRead_IN && ID_Valid_IN;
      ctrlD.Valid       = ID_Valid_IN;
      operandAD         = fwdA;
      operandBD         = fwdB;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ctrlQ      <= BUBBLE;
      operandAQ  <= '0;
      operandBQ  <= '0;
      stallCount <= '0;
    end else begin
      ctrlQ     <= ctrlD;
      operandAQ <= operandAD;
      operandBQ <= operandBD;
      if (Stall_OUT && (stallCount != {CNT_W{1'b1}})) stallCount <= stallCount + 1'b1;
    end
  end

  assign Valid_OUT       = ctrlQ.Valid;
  assign RegWrite_OUT    = ctrlQ.RegWrite;
  assign MemRead_OUT     = ctrlQ.MemRead;
  assign WriteReg_OUT    = ctrlQ.WriteReg;
  assign ALUControl_OUT  = ctrlQ.ALUControl;
  assign ShiftAmount_OUT = ctrlQ.ShiftAmount;
  assign OperandA_OUT    = operandAQ;
  assign OperandB_OUT    = operandBQ;
  assign StallCount_OUT  = stallCount;

endmodule
